// File: rtl/riscv_mem_arbiter.sv
// Shares one single-ported, variable-latency memory between the instruction-fetch port and the data port.
// Data accesses have priority. A streak limit keeps fetches from starving, and if_kill drops a wrong-path fetch.
module riscv_mem_arbiter #(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned STREAK_MAX = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned SW = $clog2(STREAK_MAX + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state, state_nx;
  logic          owner;
  logic          kill_pend;
  logic [SW-1:0] dstreak;
  logic          grant_d, grant_f;

  always_comb begin
    grant_d = d_req && (!if_req || (dstreak < SW'(STREAK_MAX)));
    grant_f = !grant_d && if_req && !if_kill;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant_d || grant_f) state_nx = ACCESS;
      ACCESS:  if (mem_ready)          state_nx = RESP;
      RESP:                            state_nx = IDLE;
      default:                         state_nx = IDLE;
    endcase
  end

  // The acks and mem_valid are decoded from flops only. A reset therefore drops them at once.
  always_comb begin
    mem_valid = (state == ACCESS);
    busy      = (state != IDLE);
    d_ack     = (state == RESP) && owner;
    if_ack    = (state == RESP) && !owner && !kill_pend;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      owner     <= 1'b0;
      kill_pend <= 1'b0;
      dstreak   <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          kill_pend <= 1'b0;
          if (grant_d) begin
            owner     <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            if (!if_req)                         dstreak <= '0;
            else if (dstreak != SW'(STREAK_MAX)) dstreak <= dstreak + 1'b1;
          end else if (grant_f) begin
            owner     <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            dstreak   <= '0;
          end
        end
        ACCESS: begin
          if (if_kill && !owner) kill_pend <= 1'b1;
          if (mem_ready) begin
            if (owner) d_rdata  <= mem_we ? '0 : mem_rdata;
            else       if_rdata <= mem_rdata[31:0];
          end
        end
        RESP: begin
          if (if_kill && !owner) kill_pend <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Randomized bench for riscv_mem_arbiter. A transaction-level model predicts the grants, the memory commands and the acks cycle by cycle.
module tb_riscv_mem_arbiter;
  localparam int unsigned SMAX = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        if_req = 1'b0, if_kill = 1'b0, if_ack;
  logic [63:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0, d_ack;
  logic [63:0] d_addr = '0, d_wdata = '0, d_rdata;
  logic        mem_valid, mem_we, mem_ready = 1'b0, busy;
  logic [63:0] mem_addr, mem_wdata, mem_rdata = '0;

  riscv_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .STREAK_MAX(SMAX)) dut (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clock = ~clock;

  int checks = 0, failures = 0;

  // reference model: phase 0 = idle, 1 = memory access, 2 = ack cycle
  int          phase = 0, streak = 0, wait_left = 0;
  bit          cur_d, cur_we, killed;
  logic [63:0] cur_addr, cur_wdata;
  logic [63:0] exp_drdata = '0;
  logic [31:0] exp_irdata = '0;
  logic [63:0] mem [64];
  int          dut_writes = 0, model_writes = 0;

  // stimulus knobs
  int          p_f = 0, p_d = 0, p_k = 0, max_lat = 3, fixed_wait = -1;
  bit          force_f = 0, force_d = 0, force_we = 0, kill_arm = 0;
  logic [63:0] force_faddr, force_daddr, force_wdata;
  bit          sat_mode = 0, seen_f = 0;
  int          drun = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    logic [5:0] idx;
    bit gd, gf;
    @(negedge clock);
    check("busy", 64'(busy), 64'(phase != 0));
    check("mem_valid", 64'(mem_valid), 64'(phase == 1));
    check("if_ack", 64'(if_ack), 64'(phase == 2 && !cur_d && !killed));
    check("d_ack", 64'(d_ack), 64'(phase == 2 && cur_d));
    check("d_rdata", d_rdata, exp_drdata);
    if (phase == 1) begin
      check("mem_addr", mem_addr, cur_addr);
      check("mem_we", 64'(mem_we), 64'(cur_we));
      if (cur_we) check("mem_wdata", mem_wdata, cur_wdata);
    end
    if (phase == 2 && !cur_d && !killed) check("if_rdata", 64'(if_rdata), 64'(exp_irdata));
    if (d_ack) drun++;
    if (if_ack) begin
      if (sat_mode && seen_f) check("starve_run", 64'(drun), 64'(SMAX));
      seen_f = 1;
      drun = 0;
    end

    // requesters: release after the ack, then possibly raise a new request
    if (phase == 2) begin
      if (cur_d) d_req = 1'b0;
      else if (!killed) if_req = 1'b0;
    end
    if (!if_req && force_f) begin
      if_req = 1'b1; if_addr = force_faddr; force_f = 0;
    end else if (!if_req && $urandom_range(99) < p_f) begin
      if_req = 1'b1; if_addr = {$urandom, $urandom};
    end
    if (!d_req && force_d) begin
      d_req = 1'b1; d_we = force_we; d_addr = force_daddr; d_wdata = force_wdata; force_d = 0;
    end else if (!d_req && $urandom_range(99) < p_d) begin
      d_req = 1'b1; d_we = $urandom_range(1) == 1; d_addr = {$urandom, $urandom}; d_wdata = {$urandom, $urandom};
    end
    if_kill = 1'b0;
    if (kill_arm && phase == 1 && !cur_d) begin
      if_kill = 1'b1; kill_arm = 0;
    end else if (phase != 2 && $urandom_range(99) < p_k) begin
      if_kill = 1'b1;
    end
    if (if_kill && phase == 1 && !cur_d) if_req = 1'b0;

    // memory responder
    mem_ready = (phase == 1 && wait_left == 0);
    idx = mem_addr[8:3];
    mem_rdata = mem_ready ? mem[idx] : {$urandom, $urandom};
    if (mem_valid && mem_ready && mem_we) dut_writes++;

    // model: state after the coming rising edge
    case (phase)
      0: begin
        gd = d_req && (!if_req || streak < int'(SMAX));
        gf = !gd && if_req && !if_kill;
        if (gd || gf) begin
          cur_d = gd;
          cur_we = gd && d_we;
          cur_addr = gd ? d_addr : if_addr;
          cur_wdata = d_wdata;
          if (gd && if_req) streak = (streak + 1 > int'(SMAX)) ? int'(SMAX) : streak + 1;
          else streak = 0;
          killed = 0;
          wait_left = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(max_lat));
          phase = 1;
        end
      end
      1: begin
        if (if_kill && !cur_d) killed = 1;
        if (mem_ready) begin
          idx = cur_addr[8:3];
          if (cur_d) exp_drdata = cur_we ? 64'h0 : mem[idx];
          else       exp_irdata = mem[idx][31:0];
          if (cur_we) begin
            mem[idx] = cur_wdata;
            model_writes++;
          end
          phase = 2;
        end else begin
          wait_left--;
        end
      end
      default: begin
        phase = 0;
        killed = 0;
      end
    endcase
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_mem_valid"}, 64'(mem_valid), 64'h0);
    check({pfx, "_mem_we"}, 64'(mem_we), 64'h0);
    check({pfx, "_mem_addr"}, mem_addr, 64'h0);
    check({pfx, "_mem_wdata"}, mem_wdata, 64'h0);
    check({pfx, "_if_ack"}, 64'(if_ack), 64'h0);
    check({pfx, "_d_ack"}, 64'(d_ack), 64'h0);
    check({pfx, "_if_rdata"}, 64'(if_rdata), 64'h0);
    check({pfx, "_d_rdata"}, d_rdata, 64'h0);
    check({pfx, "_busy"}, 64'(busy), 64'h0);
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom};
    mem[8] = 64'hABCD_1234_0000_0013;
    mem[32] = 64'h1122_3344_5566_7788;

    #1 reset_n = 1'b0;
    repeat (2) @(negedge clock);
    check_all_zero("reset");
    reset_n = 1'b1;

    // lone fetch at 0x40 with zero wait
    fixed_wait = 0; force_f = 1; force_faddr = 64'h40;
    repeat (6) step();

    // simultaneous fetch and load at 0x100, one wait cycle
    fixed_wait = 1; force_f = 1; force_faddr = 64'h48;
    force_d = 1; force_we = 0; force_daddr = 64'h100; force_wdata = '0;
    repeat (12) step();

    // store with mem_ready held off for 3 cycles
    fixed_wait = 3; force_d = 1; force_we = 1; force_daddr = 64'h8; force_wdata = 64'hDEAD_BEEF;
    repeat (9) step();

    // fetch killed during the access, then a normal fetch
    fixed_wait = 2; force_f = 1; force_faddr = 64'h80; kill_arm = 1;
    repeat (8) step();
    force_f = 1; force_faddr = 64'h40;
    repeat (8) step();

    // both ports saturated: the fetch streak guard
    fixed_wait = -1; max_lat = 2; p_f = 100; p_d = 100; sat_mode = 1; seen_f = 0; drun = 0;
    repeat (100) step();
    sat_mode = 0;

    // random traffic with occasional kills
    p_f = 30; p_d = 30; p_k = 5; max_lat = 3;
    repeat (2000) step();

    // reset while an access is in flight
    p_f = 0; p_d = 60; p_k = 0; found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      step();
      if (phase == 1) found = 1;
    end
    check("reset_find_access", 64'(found), 64'h1);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    if_req = 1'b0; d_req = 1'b0; if_kill = 1'b0; mem_ready = 1'b0;
    #1 check_all_zero("midreset");
    phase = 0; streak = 0; killed = 0; exp_drdata = '0; exp_irdata = '0;
    force_f = 0; force_d = 0; kill_arm = 0;
    @(negedge clock);
    reset_n = 1'b1;

    // after reset both ports saturated: 4 data grants come before the first fetch
    p_f = 100; p_d = 100; sat_mode = 1; seen_f = 1; drun = 0;
    repeat (60) step();

    check("write_count", 64'(dut_writes), 64'(model_writes));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
